// File: rtl/encode42_stream.sv
// encode42_stream: streaming 4-to-2 one-hot encoder with 2-entry output buffer and saturating error count.
// Define ENC42_PRIORITY_EN to encode multi-hot words to their highest set bit instead of flagging them.
module encode42_stream #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t r_state, w_next;
  logic [2:0] r_head, r_tail, w_enc;
  logic [ERR_CNT_W-1:0] r_cnt;
  logic w_push, w_pop, w_bad;
  // Entries are {index, err}
  always_comb begin
`ifdef ENC42_PRIORITY_EN
    w_enc = in[3] ? 3'b110 : in[2] ? 3'b100 : in[1] ? 3'b010 : in[0] ? 3'b000 : 3'b001;
`else
    w_enc = in == 4'b0001 ? 3'b000 : in == 4'b0010 ? 3'b010 :
            in == 4'b0100 ? 3'b100 : in == 4'b1000 ? 3'b110 : 3'b001;
`endif
  end
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_bad  = w_push && w_enc[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == EMPTY ? (w_push ? ONE : EMPTY) :
             r_state == ONE   ? (w_push == w_pop ? ONE : w_push ? FULL : EMPTY) :
                                (w_pop ? ONE : FULL);
  end
  always_comb begin
    in_ready  = r_state != FULL;
    out_valid = r_state != EMPTY;
    out       = r_head[2:1];
    out_err   = r_head[0];
    err_count = r_cnt;
  end
  // The head keeps the last popped entry while empty, so out holds its value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && (r_state == EMPTY || (r_state == ONE && w_pop))) r_head <= w_enc;
      else if (w_pop && r_state == FULL) r_head <= r_tail;
      if (w_push && r_state == ONE && !w_pop) r_tail <= w_enc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (clr_err)             r_cnt <= ERR_CNT_W'(w_bad);
    else if (w_bad && r_cnt != '1) r_cnt <= r_cnt + ERR_CNT_W'(1);
  end
endmodule
